// File: rtl/hs1_xfer_arbiter_if.sv
// HS1 transfer-arbiter bundle: two requesters' want/ready phases, buffer
// status, burst length, and the arbiter's grants, load strobe and state.
interface hs1_xfer_arbiter_if #(
  parameter int CNT_W = 3
);
  logic             WantRtHS1;
  logic             Rdy1RtHS1;
  logic             Rdy2RtHS1;
  logic             WantBmHS1;
  logic             Rdy1BmHS1;
  logic             Rdy2BmHS1;
  logic             FullIHS1;
  logic             FullOHS1;
  logic             InDoneHS1;
  logic [CNT_W-1:0] Prog;
  logic             GntRtHS1;
  logic             GntBmHS1;
  logic             LdOHS1;
  logic             DoneHS1;
  logic [2:0]       State;

  // Arbiter side.
  modport slave (
    input  WantRtHS1, Rdy1RtHS1, Rdy2RtHS1,
    input  WantBmHS1, Rdy1BmHS1, Rdy2BmHS1,
    input  FullIHS1, FullOHS1, InDoneHS1, Prog,
    output GntRtHS1, GntBmHS1, LdOHS1, DoneHS1, State
  );

  // Requester / environment side.
  modport master (
    output WantRtHS1, Rdy1RtHS1, Rdy2RtHS1,
    output WantBmHS1, Rdy1BmHS1, Rdy2BmHS1,
    output FullIHS1, FullOHS1, InDoneHS1, Prog,
    input  GntRtHS1, GntBmHS1, LdOHS1, DoneHS1, State
  );
endinterface

// File: rtl/hs1_xfer_arbiter.sv
// Round-robin arbiter granting the HS1 output path to the Rt or Bm requester
// for a burst of Prog+1 beats, then waiting for the downstream acknowledge.
module hs1_xfer_arbiter #(
  parameter int CNT_W = 3
) (
  input logic               CK,
  input logic               RSTN,
  hs1_xfer_arbiter_if.slave hs1
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    RT_XFER = 3'd2,
    BM_XFER = 3'd3,
    WAIT_IN = 3'd4
  } state_e;

  // Kept as a plain vector so the unused codes 5-7 remain representable.
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_bm_q, last_bm_d;
  logic             gnt_rt_q, gnt_rt_d;
  logic             gnt_bm_q, gnt_bm_d;
  logic             done_q, done_d;
  logic             ld;

  // Beat handshake: a requester offers a beat (valid) when both of its ready
  // phases are high; the output buffer accepts (ready) when not full. A beat
  // transfers in the cycle where valid, ready and the requester's want all hold.
  logic beat_rt, beat_bm;
  assign beat_rt = hs1.Rdy1RtHS1 & hs1.Rdy2RtHS1 & ~hs1.FullOHS1 & hs1.WantRtHS1;
  assign beat_bm = hs1.Rdy1BmHS1 & hs1.Rdy2BmHS1 & ~hs1.FullOHS1 & hs1.WantBmHS1;

  // Rt wins unless Bm also wants and Rt was the last one served.
  logic pick_rt, pick_bm;
  assign pick_rt = hs1.WantRtHS1 & (~hs1.WantBmHS1 | last_bm_q);
  assign pick_bm = hs1.WantBmHS1 & ~pick_rt;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_bm_q <= 1'b1;
      gnt_rt_q  <= 1'b0;
      gnt_bm_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_bm_q <= last_bm_d;
      gnt_rt_q  <= gnt_rt_d;
      gnt_bm_q  <= gnt_bm_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_bm_d = last_bm_q;
    gnt_rt_d  = gnt_rt_q;
    gnt_bm_d  = gnt_bm_q;
    done_d    = 1'b0;
    ld        = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_rt_d = 1'b0;
        gnt_bm_d = 1'b0;
        if ((hs1.WantRtHS1 | hs1.WantBmHS1) & ~hs1.FullIHS1) begin
          state_d = ARB;
        end
      end

      ARB: begin
        if (pick_rt) begin
          state_d   = RT_XFER;
          cnt_d     = hs1.Prog;
          last_bm_d = 1'b0;
          gnt_rt_d  = 1'b1;
          gnt_bm_d  = 1'b0;
        end else if (pick_bm) begin
          state_d   = BM_XFER;
          cnt_d     = hs1.Prog;
          last_bm_d = 1'b1;
          gnt_rt_d  = 1'b0;
          gnt_bm_d  = 1'b1;
        end else begin
          state_d  = IDLE;
          gnt_rt_d = 1'b0;
          gnt_bm_d = 1'b0;
        end
      end

      RT_XFER: begin
        if (!hs1.WantRtHS1) begin
          state_d  = IDLE;
          gnt_rt_d = 1'b0;
          gnt_bm_d = 1'b0;
        end else if (beat_rt) begin
          ld = 1'b1;
          if (cnt_q == '0) state_d = WAIT_IN;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end

      BM_XFER: begin
        if (!hs1.WantBmHS1) begin
          state_d  = IDLE;
          gnt_rt_d = 1'b0;
          gnt_bm_d = 1'b0;
        end else if (beat_bm) begin
          ld = 1'b1;
          if (cnt_q == '0) state_d = WAIT_IN;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end

      WAIT_IN: begin
        if (hs1.InDoneHS1) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          gnt_rt_d = 1'b0;
          gnt_bm_d = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        gnt_rt_d = 1'b0;
        gnt_bm_d = 1'b0;
      end
    endcase
  end

  assign hs1.GntRtHS1 = gnt_rt_q;
  assign hs1.GntBmHS1 = gnt_bm_q;
  assign hs1.LdOHS1   = ld;
  assign hs1.DoneHS1  = done_q;
  assign hs1.State    = state_q;

endmodule

// File: tb/tb_hs1_xfer_arbiter.sv
// Directed bench for hs1_xfer_arbiter: arbitration, burst length, stalls,
// abort, input-full gating, asynchronous reset and illegal-state recovery.
module tb_hs1_xfer_arbiter;

  logic CK;
  logic RSTN;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] exp_q[$];
  logic       ld_exp_q[$];
  logic       gnt_exp_q[$];
  logic       done_exp_q[$];

  hs1_xfer_arbiter_if #(.CNT_W(3)) hs1 ();

  hs1_xfer_arbiter #(.CNT_W(3)) dut (
    .CK   (CK),
    .RSTN (RSTN),
    .hs1  (hs1.slave)
  );

  // Clock / reset
  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Driver tasks
  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    RSTN           = 1'b0;
    hs1.WantRtHS1  = 1'b0;
    hs1.Rdy1RtHS1  = 1'b0;
    hs1.Rdy2RtHS1  = 1'b0;
    hs1.WantBmHS1  = 1'b0;
    hs1.Rdy1BmHS1  = 1'b0;
    hs1.Rdy2BmHS1  = 1'b0;
    hs1.FullIHS1   = 1'b0;
    hs1.FullOHS1   = 1'b0;
    hs1.InDoneHS1  = 1'b0;
    hs1.Prog       = 3'd0;

    // Reset state
    #2;
    chk3("rst_state", hs1.State, 3'd0);
    chk1("rst_gnt_rt", hs1.GntRtHS1, 1'b0);
    chk1("rst_gnt_bm", hs1.GntBmHS1, 1'b0);
    chk1("rst_done", hs1.DoneHS1, 1'b0);
    chk1("rst_ld", hs1.LdOHS1, 1'b0);
    #6 RSTN = 1'b1;

    // Both want continuously, single-beat bursts: Rt, Bm, Rt, Bm
    hs1.WantRtHS1 = 1'b1;
    hs1.WantBmHS1 = 1'b1;
    hs1.Rdy1RtHS1 = 1'b1;
    hs1.Rdy2RtHS1 = 1'b1;
    hs1.Rdy1BmHS1 = 1'b1;
    hs1.Rdy2BmHS1 = 1'b1;
    hs1.InDoneHS1 = 1'b1;
    hs1.Prog      = 3'd0;
    for (int b = 0; b < 4; b++) begin
      step();
      chk3("rr_arb", hs1.State, 3'd1);
      step();
      chk3("rr_xfer", hs1.State, (b % 2 == 0) ? 3'd2 : 3'd3);
      chk1("rr_gnt_rt", hs1.GntRtHS1, (b % 2 == 0));
      chk1("rr_gnt_bm", hs1.GntBmHS1, (b % 2 != 0));
      chk1("rr_ld", hs1.LdOHS1, 1'b1);
      step();
      chk3("rr_wait", hs1.State, 3'd4);
      chk1("rr_excl", hs1.GntRtHS1 & hs1.GntBmHS1, 1'b0);
      step();
      chk3("rr_idle", hs1.State, 3'd0);
      chk1("rr_done", hs1.DoneHS1, 1'b1);
    end
    hs1.WantRtHS1 = 1'b0;
    hs1.WantBmHS1 = 1'b0;
    step();
    chk3("rr_end_state", hs1.State, 3'd0);
    chk1("rr_end_done", hs1.DoneHS1, 1'b0);

    // Rt burst, Prog=2: states 0,1,2,2,2,4,0 with three load strobes
    exp_q      = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4, 3'd0};
    ld_exp_q   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    gnt_exp_q  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    done_exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    hs1.WantRtHS1 = 1'b1;
    hs1.Prog      = 3'd2;
    #1;
    for (int i = 0; i < 7; i++) begin
      chk3("t1_state", hs1.State, exp_q.pop_front());
      chk1("t1_ld", hs1.LdOHS1, ld_exp_q.pop_front());
      chk1("t1_gnt_rt", hs1.GntRtHS1, gnt_exp_q.pop_front());
      chk1("t1_done", hs1.DoneHS1, done_exp_q.pop_front());
      if (i == 6) hs1.WantRtHS1 = 1'b0;
      step();
    end
    chk3("t1_end_state", hs1.State, 3'd0);
    chk1("t1_done_once", hs1.DoneHS1, 1'b0);

    // Bm burst, Prog=1, output full for 5 cycles after the first beat
    hs1.WantBmHS1 = 1'b1;
    hs1.Prog      = 3'd1;
    step();
    chk3("t3_arb", hs1.State, 3'd1);
    step();
    chk3("t3_xfer", hs1.State, 3'd3);
    chk1("t3_gnt_bm", hs1.GntBmHS1, 1'b1);
    chk1("t3_ld_first", hs1.LdOHS1, 1'b1);
    step();
    hs1.FullOHS1 = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk1("t3_ld_stall", hs1.LdOHS1, 1'b0);
      chk3("t3_state_stall", hs1.State, 3'd3);
      step();
    end
    hs1.FullOHS1 = 1'b0;
    #1;
    chk1("t3_ld_second", hs1.LdOHS1, 1'b1);
    step();
    chk3("t3_wait", hs1.State, 3'd4);
    chk1("t3_gnt_hold", hs1.GntBmHS1, 1'b1);
    step();
    chk3("t3_idle", hs1.State, 3'd0);
    chk1("t3_done", hs1.DoneHS1, 1'b1);
    hs1.WantBmHS1 = 1'b0;
    step();
    chk1("t3_done_once", hs1.DoneHS1, 1'b0);

    // Rt aborts after 1 of 4 beats; Bm pending wins the next tie
    hs1.WantRtHS1 = 1'b1;
    hs1.WantBmHS1 = 1'b1;
    hs1.Prog      = 3'd3;
    step();
    chk3("t4_arb", hs1.State, 3'd1);
    step();
    chk3("t4_xfer", hs1.State, 3'd2);
    chk1("t4_gnt_rt", hs1.GntRtHS1, 1'b1);
    chk1("t4_ld_first", hs1.LdOHS1, 1'b1);
    step();
    hs1.WantRtHS1 = 1'b0;
    #1;
    chk1("t4_ld_abort", hs1.LdOHS1, 1'b0);
    chk3("t4_state_abort", hs1.State, 3'd2);
    step();
    chk3("t4_idle", hs1.State, 3'd0);
    chk1("t4_gnt_clr", hs1.GntRtHS1, 1'b0);
    chk1("t4_no_done", hs1.DoneHS1, 1'b0);
    hs1.WantRtHS1 = 1'b1;
    step();
    chk3("t4_arb2", hs1.State, 3'd1);
    step();
    chk3("t4_bm_state", hs1.State, 3'd3);
    chk1("t4_gnt_bm", hs1.GntBmHS1, 1'b1);
    chk1("t4_gnt_rt_low", hs1.GntRtHS1, 1'b0);
    hs1.WantRtHS1 = 1'b0;
    hs1.WantBmHS1 = 1'b0;
    step();
    chk3("t4_bm_abort", hs1.State, 3'd0);
    chk1("t4_bm_no_done", hs1.DoneHS1, 1'b0);

    // Input full holds IDLE; Prog=7 gives exactly 8 beats
    hs1.WantRtHS1 = 1'b1;
    hs1.FullIHS1  = 1'b1;
    hs1.Prog      = 3'd7;
    step();
    chk3("t5_hold0", hs1.State, 3'd0);
    step();
    chk3("t5_hold1", hs1.State, 3'd0);
    hs1.FullIHS1 = 1'b0;
    step();
    chk3("t5_arb", hs1.State, 3'd1);
    hs1.FullIHS1 = 1'b1;
    step();
    chk3("t5_xfer", hs1.State, 3'd2);
    chk1("t5_gnt_rt", hs1.GntRtHS1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk3("t5_beat_state", hs1.State, 3'd2);
      chk1("t5_beat_ld", hs1.LdOHS1, 1'b1);
      step();
    end
    chk3("t5_wait", hs1.State, 3'd4);
    chk1("t5_wait_ld", hs1.LdOHS1, 1'b0);
    step();
    chk3("t5_idle", hs1.State, 3'd0);
    chk1("t5_done", hs1.DoneHS1, 1'b1);
    step();
    chk3("t5_fulli_block", hs1.State, 3'd0);
    hs1.WantRtHS1 = 1'b0;
    hs1.FullIHS1  = 1'b0;

    // Asynchronous reset while waiting for the acknowledge
    hs1.WantRtHS1 = 1'b1;
    hs1.InDoneHS1 = 1'b0;
    hs1.Prog      = 3'd0;
    step();
    step();
    step();
    chk3("t6_wait", hs1.State, 3'd4);
    chk1("t6_gnt_rt", hs1.GntRtHS1, 1'b1);
    step();
    chk3("t6_wait_hold", hs1.State, 3'd4);
    #3 RSTN = 1'b0;
    #1;
    chk3("t6_rst_state", hs1.State, 3'd0);
    chk1("t6_rst_gnt", hs1.GntRtHS1, 1'b0);
    chk1("t6_rst_done", hs1.DoneHS1, 1'b0);
    chk1("t6_rst_ld", hs1.LdOHS1, 1'b0);
    hs1.InDoneHS1 = 1'b1;
    hs1.WantRtHS1 = 1'b0;
    #2 RSTN = 1'b1;
    step();
    chk3("t6_rel_state", hs1.State, 3'd0);
    chk1("t6_rel_done", hs1.DoneHS1, 1'b0);

    // Unused encoding returns to IDLE regardless of requests
    hs1.WantRtHS1 = 1'b1;
    force dut.state_q = 3'd6;
    #1;
    chk3("t7_forced", hs1.State, 3'd6);
    chk1("t7_ld", hs1.LdOHS1, 1'b0);
    release dut.state_q;
    step();
    chk3("t7_recover", hs1.State, 3'd0);
    chk1("t7_gnt_rt", hs1.GntRtHS1, 1'b0);
    hs1.WantRtHS1 = 1'b0;

    // Report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
